// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the core's data-memory path.
//   mem_in_s      : core -> memory request {write_data, valid, wen, byte_not_word, yumi}
//   mem_out_s     : memory -> core response {read_data, valid, yumi}
//   dmem_state_e  : controller FSM states
//   dmem_lat_max_gp : largest supported request-to-response latency
package data_mem_ctrl_pkg;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;           // core acknowledges the response
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;           // memory accepts the request
  } mem_out_s;

  typedef enum logic [1:0] {
    DM_IDLE,
    DM_BUSY,
    DM_RESP
  } dmem_state_e;

  localparam int unsigned dmem_lat_max_gp = 15;

endpackage

// File: rtl/data_mem_ctrl_array.sv
// Synchronous single-port RAM, 2^addr_width_p x 32 bits, byte-enable write and
// registered read. Read and write share the enable edge; the read returns the
// word as it was before the write. Kept as its own module so an SRAM macro can
// replace it.
//   clk     : clock
//   en_i    : access enable (read and write on this edge)
//   be_i    : byte-lane write enables, all zero for a read
//   addr_i  : word index
//   wdata_i : write data, lane b taken from bits [8b+7:8b]
//   rdata_o : read data, holds until the next enabled edge
module dmem_array #(
  parameter int unsigned addr_width_p = 10
) (
  input  logic                    clk,
  input  logic                    en_i,
  input  logic [3:0]              be_i,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic [31:0]             wdata_i,
  output logic [31:0]             rdata_o
);

  localparam int unsigned Depth = 1 << addr_width_p;

  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_o <= mem_q[addr_i];
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory stage behind the core's load/store path. Accepts one request at a
// time through the valid/yumi handshake, performs the array access at the accept
// edge, and presents the response latency_p cycles later, held until the core
// acknowledges it.
//   clk    : clock
//   reset  : synchronous active-high reset
//   mem_i  : request and response acknowledge from the core
//   addr_i : byte address, sampled only at accept
//   mem_o  : request accept (yumi) and response (valid, read_data)
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned addr_width_p = 10,
  parameter int unsigned latency_p    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  mem_in_s     mem_i,
  input  logic [31:0] addr_i,
  output mem_out_s    mem_o
);

  if (latency_p < 1 || latency_p > dmem_lat_max_gp) begin : g_bad_latency
    $fatal(1, "data_mem_ctrl: latency_p must be in 1..15");
  end

  dmem_state_e state_q;
  logic [3:0]  cnt_q;
  logic        valid_q;
  logic        wen_q;
  logic        bnw_q;
  logic [1:0]  lane_q;

  logic        accept;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  rbyte;

  assign accept = (state_q == DM_IDLE) && mem_i.valid && !reset;

  // Byte stores replicate the low byte into every lane and enable only one.
  always_comb begin
    be    = 4'b1111;
    wdata = mem_i.write_data;
    if (mem_i.byte_not_word) begin
      be    = 4'b0001 << addr_i[1:0];
      wdata = {4{mem_i.write_data[7:0]}};
    end
    if (!mem_i.wen) begin
      be = 4'b0000;
    end
  end

  dmem_array #(
    .addr_width_p(addr_width_p)
  ) u_array (
    .clk    (clk),
    .en_i   (accept),
    .be_i   (be),
    .addr_i (addr_i[addr_width_p+1:2]),
    .wdata_i(wdata),
    .rdata_o(rdata)
  );

  // Address bits above the array are deliberately ignored (wrap-around).
  logic unused_addr;
  assign unused_addr = ^addr_i[31:addr_width_p+2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DM_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      wen_q   <= 1'b0;
      bnw_q   <= 1'b0;
      lane_q  <= '0;
    end else begin
      unique case (state_q)
        DM_IDLE: begin
          if (mem_i.valid) begin
            wen_q  <= mem_i.wen;
            bnw_q  <= mem_i.byte_not_word;
            lane_q <= addr_i[1:0];
            cnt_q  <= 4'(latency_p - 1);
            if (latency_p == 1) begin
              state_q <= DM_RESP;
              valid_q <= 1'b1;
            end else begin
              state_q <= DM_BUSY;
            end
          end
        end
        DM_BUSY: begin
          // Leaving on the edge the count reaches zero gives exactly latency_p.
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_q <= DM_RESP;
            valid_q <= 1'b1;
          end
        end
        DM_RESP: begin
          if (mem_i.yumi) begin
            state_q <= DM_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= DM_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // The array output holds between accepts, so the response stays stable in RESP.
  assign rbyte = rdata[{lane_q, 3'b000} +: 8];

  always_comb begin
    mem_o.read_data = '0;
    if (valid_q && !wen_q) begin
      mem_o.read_data = bnw_q ? {24'b0, rbyte} : rdata;
    end
    mem_o.valid = valid_q;
    mem_o.yumi  = accept;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: latency 2 instance for the main plan and a
// latency 1 instance for the no-BUSY path.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  mem_in_s     min  [2];
  mem_out_s    mout [2];
  logic [31:0] addr [2];

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_ctrl #(
    .addr_width_p(10),
    .latency_p   (2)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .mem_i (min[0]),
    .addr_i(addr[0]),
    .mem_o (mout[0])
  );

  data_mem_ctrl #(
    .addr_width_p(10),
    .latency_p   (1)
  ) u_dut_l1 (
    .clk   (clk),
    .reset (reset),
    .mem_i (min[1]),
    .addr_i(addr[1]),
    .mem_o (mout[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request from a negedge, check accept, latency, hold and release.
  task automatic run_op(input int sel, input logic wen, input logic bnw,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp, input int hold, input string tag);
    int lat;
    lat = (sel == 0) ? 2 : 1;
    min[sel].valid         = 1'b1;
    min[sel].wen           = wen;
    min[sel].byte_not_word = bnw;
    min[sel].write_data    = wd;
    min[sel].yumi          = 1'b0;
    addr[sel]              = a;
    #1 check_eq({tag, "_acc"}, 32'(mout[sel].yumi), 32'd1);
    @(posedge clk);
    @(negedge clk);
    min[sel].valid = 1'b0;
    for (int i = 0; i < lat - 1; i++) begin
      #1 check_eq({tag, "_busy"}, 32'(mout[sel].valid), 32'd0);
      @(negedge clk);
    end
    #1 check_eq({tag, "_valid"}, 32'(mout[sel].valid), 32'd1);
    check_eq({tag, "_data"}, mout[sel].read_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1 check_eq({tag, "_hold_v"}, 32'(mout[sel].valid), 32'd1);
      check_eq({tag, "_hold_d"}, mout[sel].read_data, exp);
    end
    min[sel].yumi = 1'b1;
    @(negedge clk);
    min[sel].yumi = 1'b0;
    #1 check_eq({tag, "_release"}, 32'(mout[sel].valid), 32'd0);
  endtask

  initial begin
    min[0]  = '0;
    min[1]  = '0;
    addr[0] = '0;
    addr[1] = '0;
    reset   = 1'b1;
    min[0].valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 check_eq("rst_yumi", 32'(mout[0].yumi), 32'd0);
    check_eq("rst_valid", 32'(mout[0].valid), 32'd0);
    check_eq("rst_data", mout[0].read_data, 32'd0);
    min[0].valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Word store then load
    run_op(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 2, "st_w10");
    run_op(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 0, "ld_w10");

    // Byte lanes
    run_op(0, 1'b1, 1'b0, 32'h20, 32'h11223344, 32'h0, 0, "st_w20");
    run_op(0, 1'b1, 1'b1, 32'h22, 32'hFFFFFFAB, 32'h0, 0, "st_b22");
    run_op(0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h11AB3344, 0, "ld_w20");
    run_op(0, 1'b0, 1'b1, 32'h23, 32'h0, 32'h00000011, 0, "ld_b23");
    run_op(0, 1'b0, 1'b1, 32'h22, 32'h0, 32'h000000AB, 0, "ld_b22");

    // Wrap-around and forced word alignment
    run_op(0, 1'b1, 1'b0, 32'h1004, 32'hCAFEF00D, 32'h0, 0, "st_wrap");
    run_op(0, 1'b0, 1'b0, 32'h0004, 32'h0, 32'hCAFEF00D, 0, "ld_wrap");
    run_op(0, 1'b0, 1'b0, 32'h0006, 32'h0, 32'hCAFEF00D, 0, "ld_unal");
    run_op(0, 1'b0, 1'b1, 32'h1007, 32'h0, 32'h000000CA, 0, "ld_bwrap");

    // Handshake stress: valid held high throughout, yumi pulse in BUSY
    min[0].valid         = 1'b1;
    min[0].wen           = 1'b0;
    min[0].byte_not_word = 1'b0;
    addr[0]              = 32'h10;
    #1 check_eq("hs_acc", 32'(mout[0].yumi), 32'd1);
    @(posedge clk);
    @(negedge clk);
    min[0].yumi = 1'b1;
    #1 check_eq("hs_busy_yumi", 32'(mout[0].yumi), 32'd0);
    check_eq("hs_busy_valid", 32'(mout[0].valid), 32'd0);
    @(negedge clk);
    min[0].yumi = 1'b0;
    #1 check_eq("hs_resp_valid", 32'(mout[0].valid), 32'd1);
    check_eq("hs_resp_yumi", 32'(mout[0].yumi), 32'd0);
    check_eq("hs_resp_data", mout[0].read_data, 32'hDEADBEEF);
    @(negedge clk);
    #1 check_eq("hs_hold_valid", 32'(mout[0].valid), 32'd1);
    check_eq("hs_hold_yumi", 32'(mout[0].yumi), 32'd0);
    min[0].yumi = 1'b1;
    @(negedge clk);
    min[0].yumi = 1'b0;
    #1 check_eq("hs_reacc_yumi", 32'(mout[0].yumi), 32'd1);
    check_eq("hs_reacc_valid", 32'(mout[0].valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    min[0].valid = 1'b0;
    #1 check_eq("hs2_busy", 32'(mout[0].valid), 32'd0);
    @(negedge clk);
    #1 check_eq("hs2_valid", 32'(mout[0].valid), 32'd1);
    check_eq("hs2_data", mout[0].read_data, 32'hDEADBEEF);
    min[0].yumi = 1'b1;
    @(negedge clk);
    min[0].yumi = 1'b0;
    #1 check_eq("hs2_release", 32'(mout[0].valid), 32'd0);

    // Reset in BUSY of a store; the store stays committed
    min[0].valid         = 1'b1;
    min[0].wen           = 1'b1;
    min[0].byte_not_word = 1'b0;
    min[0].write_data    = 32'h00000055;
    addr[0]              = 32'h30;
    #1 check_eq("rm_acc", 32'(mout[0].yumi), 32'd1);
    @(posedge clk);
    @(negedge clk);
    min[0].valid = 1'b0;
    reset        = 1'b1;
    #1 check_eq("rm_busy", 32'(mout[0].valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check_eq("rm_discard", 32'(mout[0].valid), 32'd0);
    @(negedge clk);
    #1 check_eq("rm_idle", 32'(mout[0].valid), 32'd0);
    run_op(0, 1'b0, 1'b0, 32'h30, 32'h0, 32'h00000055, 0, "rm_ld");

    // Latency 1 instance: response right after accept
    run_op(1, 1'b1, 1'b0, 32'h8, 32'h12345678, 32'h0, 1, "l1_st");
    run_op(1, 1'b0, 1'b1, 32'h9, 32'h0, 32'h00000056, 0, "l1_ldb");
    run_op(1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h12345678, 0, "l1_ldw");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
